// File: rtl/operand_fwd_scoreboard_pkg.sv
// Shared operand-select encodings and sizing helpers for the operand forwarding scoreboard.
package operand_fwd_scoreboard_pkg;

   typedef enum logic [1:0] {
      SEL_REG = 2'd0,
      SEL_PC  = 2'd1,
      SEL_FWD = 2'd2
   } sel_e;

   localparam logic [4:0] REG_X0 = 5'd0;

   // Width of a stage index; a single-entry scoreboard still needs one bit.
   function automatic int sw_of(input int depth);
      return (depth < 2) ? 1 : $clog2(depth);
   endfunction

   // Width of the per-entry load latency down-counter, never narrower than one bit.
   function automatic int cw_of(input int lat);
      return (lat < 1) ? 1 : $clog2(lat + 1);
   endfunction

endpackage

// File: rtl/operand_fwd_scoreboard_if.sv
// Execute-stage operand bus: instruction fields in, operand selects and stall out.
interface operand_fwd_scoreboard_if #(
   parameter int NUM_SRC = 2,
   parameter int SW      = 1
);
   logic                    mem_stall;
   logic                    flush;
   logic                    x_valid;
   logic [5*NUM_SRC-1:0]    x_rs;
   logic [NUM_SRC-1:0]      x_rs_used;
   logic [NUM_SRC-1:0]      x_use_pc;
   logic [4:0]              x_rd;
   logic                    x_rd_we;
   logic                    x_is_load;
   logic [2*NUM_SRC-1:0]    sel;
   logic [SW*NUM_SRC-1:0]   fwd_stage;
   logic                    stall;
   logic [31:0]             stall_cycles;

   modport master (
      output mem_stall, flush, x_valid, x_rs, x_rs_used, x_use_pc, x_rd, x_rd_we, x_is_load,
      input  sel, fwd_stage, stall, stall_cycles
   );

   modport slave (
      input  mem_stall, flush, x_valid, x_rs, x_rs_used, x_use_pc, x_rd, x_rd_we, x_is_load,
      output sel, fwd_stage, stall, stall_cycles
   );
endinterface

// File: rtl/operand_fwd_scoreboard_fwd_match.sv
// One operand channel: finds the youngest in-flight writer of rs and picks its source.
module operand_fwd_scoreboard_fwd_match
   import operand_fwd_scoreboard_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int CW    = 1,
   parameter int SW    = 1
) (
   input  logic [4:0]          rs,
   input  logic                used,
   input  logic                use_pc,
   input  logic [DEPTH-1:0]    e_v,
   input  logic [5*DEPTH-1:0]  e_rd,
   input  logic [CW*DEPTH-1:0] e_cnt,
   output logic [1:0]          sel,
   output logic [SW-1:0]       stage,
   output logic                hazard
);

   logic found;

   // Lowest index wins: E[0] holds the youngest writer, so its value shadows older ones.
   always_comb begin
      sel    = SEL_REG;
      stage  = '0;
      hazard = 1'b0;
      found  = 1'b0;
      if (use_pc) begin
         sel = SEL_PC;
      end else if (used && (rs != REG_X0)) begin
         for (int k = 0; k < DEPTH; k++) begin
            if (!found && e_v[k] && (e_rd[5*k +: 5] == rs)) begin
               found = 1'b1;
               if (e_cnt[CW*k +: CW] == '0) begin
                  sel   = SEL_FWD;
                  stage = SW'(k);
               end else begin
                  hazard = 1'b1;
               end
            end
         end
      end
   end

endmodule

// File: rtl/operand_fwd_scoreboard.sv
// Execute-stage operand select and load-use hazard unit with a shift-register scoreboard.
module operand_fwd_scoreboard
   import operand_fwd_scoreboard_pkg::*;
#(
   parameter int NUM_SRC  = 2,
   parameter int DEPTH    = 2,
   parameter int LOAD_LAT = 0,
   parameter int SW       = sw_of(DEPTH)
) (
   input logic                   clk,
   input logic                   rst,
   operand_fwd_scoreboard_if.slave bus
);

   localparam int CW = cw_of(LOAD_LAT);

   logic [DEPTH-1:0]      e_v;
   logic [5*DEPTH-1:0]    e_rd;
   logic [CW*DEPTH-1:0]   e_cnt;
   logic [CW*DEPTH-1:0]   cnt_dec;
   logic [NUM_SRC-1:0]    hazard;
   logic [2*NUM_SRC-1:0]  sel_w;
   logic [SW*NUM_SRC-1:0] stage_w;
   logic [31:0]           stall_cycles;
   logic                  stall_int;
   logic                  advance;
   logic                  issue;

   for (genvar i = 0; i < NUM_SRC; i++) begin : g_ch
      operand_fwd_scoreboard_fwd_match #(
         .DEPTH (DEPTH),
         .CW    (CW),
         .SW    (SW)
      ) u_match (
         .rs     (bus.x_rs[5*i +: 5]),
         .used   (bus.x_rs_used[i]),
         .use_pc (bus.x_use_pc[i]),
         .e_v    (e_v),
         .e_rd   (e_rd),
         .e_cnt  (e_cnt),
         .sel    (sel_w[2*i +: 2]),
         .stage  (stage_w[SW*i +: SW]),
         .hazard (hazard[i])
      );
   end

   // A killed or invalid X instruction never stalls, even if its operands are not ready.
   assign stall_int = bus.x_valid & ~bus.flush & (|hazard);
   assign advance   = ~bus.mem_stall;
   assign issue     = bus.x_valid & ~bus.flush & ~stall_int;

   // Latency counters tick down as entries move toward retirement.
   always_comb begin
      cnt_dec = e_cnt;
      for (int k = 0; k < DEPTH; k++) begin
         if (e_cnt[CW*k +: CW] != '0) begin
            cnt_dec[CW*k +: CW] = e_cnt[CW*k +: CW] - CW'(1);
         end
      end
   end

   // Scoreboard shift and stall counter; both freeze together under mem_stall.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         e_v          <= '0;
         e_rd         <= '0;
         e_cnt        <= '0;
         stall_cycles <= '0;
      end else if (advance) begin
         for (int k = DEPTH - 1; k >= 1; k--) begin
            e_v[k]            <= e_v[k-1];
            e_rd[5*k +: 5]    <= e_rd[5*(k-1) +: 5];
            e_cnt[CW*k +: CW] <= cnt_dec[CW*(k-1) +: CW];
         end
         e_v[0]       <= issue & bus.x_rd_we & (bus.x_rd != REG_X0);
         e_rd[4:0]    <= bus.x_rd;
         e_cnt[CW-1:0] <= (issue & bus.x_is_load) ? CW'(LOAD_LAT) : '0;
         if (stall_int) begin
            stall_cycles <= stall_cycles + 32'd1;
         end
      end
   end

   assign bus.sel          = sel_w;
   assign bus.fwd_stage    = stage_w;
   assign bus.stall        = stall_int;
   assign bus.stall_cycles = stall_cycles;

endmodule

// File: doc/operand_fwd_scoreboard.md
Name: operand_fwd_scoreboard

Overview:
- Parametrised operand-select and hazard unit for the Execute stage. It supersedes the single-channel, fixed-depth A/B selectors.
- Tracks in-flight register writers in a DEPTH-entry shift-register scoreboard behind X. For each of NUM_SRC operand channels it selects register, PC or forwarded data, and reports which stage the forwarded data comes from.
- Raises a load-use stall when a producer's data is not yet available (configurable load latency). Counts stall cycles for performance monitoring.

Parameters:
- NUM_SRC, 2, number of operand channels checked in X (A, B, branch-compare, ...).
- DEPTH, 2, scoreboard entries after X; E[0] = M stage. Legal range 1..4.
- LOAD_LAT, 0, advancing cycles after a load enters E[0] before its data is forwardable. Must satisfy LOAD_LAT < DEPTH.
- SW, max(1,$clog2(DEPTH)), width of each stage index.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-low: scoreboard clears while low.
- mem_stall  in  1  external freeze; the scoreboard holds all state.
- flush  in  1  kills the X instruction this cycle (redirect).
- x_valid  in  1  X holds a live instruction.
- x_rs  in  5*NUM_SRC  source register index per channel.
- x_rs_used  in  NUM_SRC  channel reads a register.
- x_use_pc  in  NUM_SRC  channel takes the PC (branch/JAL/AUIPC A-operand).
- x_rd  in  5  destination of the X instruction.
- x_rd_we  in  1  X instruction writes rd.
- x_is_load  in  1  X instruction is a load.
- sel  out  2*NUM_SRC  per channel: 0 SEL_REG, 1 SEL_PC, 2 SEL_FWD.
- fwd_stage  out  SW*NUM_SRC  per channel: source entry index, valid when sel=SEL_FWD, else 0.
- stall  out  1  hold F/X and insert a bubble into M.
- stall_cycles  out  32  performance counter.

Behaviour:
- Entry E[k] fields: v, rd[4:0], cnt (width $clog2(LOAD_LAT+1), minimum 1).
- Reset (rst low, async): all v=0, cnt=0, stall_cycles=0. Combinational outputs then give sel = PC for channels with x_use_pc=1, otherwise REG; fwd_stage=0; stall=0.
- Advance condition: ~mem_stall. When mem_stall=1, all entries and cnt hold.
- On advance:
  - E[k] <= E[k-1] for k≥1; E[DEPTH-1] retires. The regfile is write-through, so retired values are read as SEL_REG.
  - E[0] <= bubble (v=0) if stall | flush | ~x_valid. Otherwise v = x_rd_we & (x_rd!=0), rd = x_rd, cnt = x_is_load ? LOAD_LAT : 0.
  - Every shifted entry with cnt>0 decrements cnt by 1.
- Per-channel select (combinational):
  - If x_use_pc[i]: sel=PC, no hazard.
  - Else if ~x_rs_used[i] or rs==0: sel=REG.
  - Else take the lowest-index (youngest) E[k] with v & rd==rs.
    - Found with cnt==0: sel=FWD, fwd_stage=k.
    - Found with cnt>0: hazard_i=1, sel=REG.
    - None found: sel=REG.
- stall = x_valid & ~flush & OR(hazard_i). stall does not depend on mem_stall.
- stall_cycles: increments (wrapping modulo 2^32) on each edge where stall & ~mem_stall.
- Simultaneous events:
  - flush and hazard together: stall=0 and a bubble is inserted.
  - mem_stall and stall together: everything holds and the counter does not increment.
- With LOAD_LAT=1, a dependent instruction immediately behind a load stalls exactly 1 cycle, then forwards from E[1]. With LOAD_LAT=0 it forwards from E[0] with no stall.

Decomposition:
- Shared package/header (extends ControlLogicSel.vh): SEL_REG=2'd0, SEL_PC=2'd1, SEL_FWD=2'd2, REG_X0=5'd0.
- One natural sub-module: fwd_match. It is combinational and instantiated NUM_SRC times. Inputs: rs, used, use_pc, packed entry vectors. Outputs: sel, stage, hazard.
- The scoreboard shift register and the counter live in the top module.

Test Plan:
- DEPTH=2, LOAD_LAT=0. Sequence: add x5,x1,x2 then sub x6,x5,x3. -> In sub's X cycle: sel[0]=FWD, fwd_stage[0]=0, stall=0.
- LOAD_LAT=1. Sequence: lw x7 then add x8,x7,x7. -> stall=1 for exactly 1 cycle and E[0] becomes a bubble. Next cycle: both channels FWD with stage=1, and stall_cycles=1.
- Instruction writing x0 (x_rd_we=1), then a consumer with rs=x0. -> sel=REG, stall=0, E[0].v=0.
- Two writers to x9 back-to-back, then a consumer of x9. -> fwd_stage=0, the youngest writer. After one bubble-free advance with a non-x9 instruction: fwd_stage=1.
- Hazard present with flush=1 -> stall=0 and a bubble is inserted. Separately, mem_stall held 3 cycles -> entries unchanged, stall_cycles unchanged, and the stall level is preserved.
- rst driven low mid-stall (LOAD_LAT=1) -> stall=0 and stall_cycles=0 immediately, with no clock edge. After release, the first instruction sees sel=REG.
